// File: rtl/ipm_bus_pkg.sv
// Shared types and sizing helpers for the IPM 8-bit MCU bus.
// Used by the bus master and by IPM-side logic.
package ipm_bus_pkg;

  localparam int IPM_ADDR_W = 4;
  localparam int IPM_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } ipm_st_e;

  // Phase counter width: enough bits to hold the largest phase length.
  function automatic int ipm_cnt_w(
    input int s,
    input int t,
    input int h
  );
    int m;
    m = s;
    if (t > m) m = t;
    if (h > m) m = h;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ipm_bus_master_if.sv
// Command handshake and IPM bus pins of the bus master.
// master = the initiator's view, slave = host/responder view.
interface ipm_bus_master_if;
  import ipm_bus_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [IPM_ADDR_W-1:0] cmd_addr;
  logic [IPM_DATA_W-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [IPM_DATA_W-1:0] rsp_rdata;
  logic [IPM_ADDR_W-1:0] bus_addr;
  logic                  bus_rd;
  logic                  bus_wr;
  logic [IPM_DATA_W-1:0] bus_data_o;
  logic                  bus_data_oe;
  logic [IPM_DATA_W-1:0] bus_data_i;
  logic                  bus_int;
  logic                  irq_pending;
  logic                  irq_clr;

  modport master (
    input  cmd_valid,
    input  cmd_write,
    input  cmd_addr,
    input  cmd_wdata,
    input  bus_data_i,
    input  bus_int,
    input  irq_clr,
    output cmd_ready,
    output rsp_valid,
    output rsp_rdata,
    output bus_addr,
    output bus_rd,
    output bus_wr,
    output bus_data_o,
    output bus_data_oe,
    output irq_pending
  );

  modport slave (
    output cmd_valid,
    output cmd_write,
    output cmd_addr,
    output cmd_wdata,
    output bus_data_i,
    output bus_int,
    output irq_clr,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  bus_addr,
    input  bus_rd,
    input  bus_wr,
    input  bus_data_o,
    input  bus_data_oe,
    input  irq_pending
  );

endinterface

// File: rtl/ipm_bus_master_sync2.sv
// Two-flop synchronizer, async active-low reset, any width.
// Shared between the MCU-side master and the IPM side.
module ipm_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  // Two register stages to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/ipm_bus_master.sv
// IPM MCU-bus initiator: valid/ready command to timed RD/WR cycle.
// Define IPM_BM_IRQ_LATCH_EN for a sticky, clearable irq_pending.
import ipm_bus_pkg::*;

module ipm_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input logic               clk,
  input logic               rst_n,
  ipm_bus_master_if.master  b
);

  if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1) begin : g_prm_chk
    $error("ipm_bus_master: phase lengths must be >= 1");
  end

  localparam int CW = ipm_cnt_w(SETUP_CYC, STROBE_CYC, HOLD_CYC);
  localparam logic [CW-1:0] S_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] T_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] H_LD = CW'(HOLD_CYC - 1);

  ipm_st_e               r_st;
  ipm_st_e               w_st_nx;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nx;
  logic                  w_acc;
  logic                  w_last;
  logic                  w_act;
  logic                  w_cap;
  logic                  r_write;
  logic [IPM_ADDR_W-1:0] r_addr;
  logic [IPM_DATA_W-1:0] r_wdata;
  logic [IPM_DATA_W-1:0] r_rdata;
  logic                  w_int_s;

  assign w_acc  = (r_st == ST_IDLE) & b.cmd_valid;
  assign w_last = (r_cnt == '0);
  assign w_cap  = (r_st == ST_STROBE) & w_last & ~r_write;
  assign w_act  = (r_st == ST_SETUP)
                | (r_st == ST_STROBE)
                | (r_st == ST_HOLD);

  // State and phase counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st  <= ST_IDLE;
      r_cnt <= '0;
    end else begin
      r_st  <= w_st_nx;
      r_cnt <= w_cnt_nx;
    end
  end

  // Next state; each phase reloads the counter and runs it down to 0.
  always_comb begin
    w_st_nx  = r_st;
    w_cnt_nx = r_cnt;
    unique case (r_st)
      ST_IDLE: begin
        if (w_acc) begin
          w_st_nx  = ST_SETUP;
          w_cnt_nx = S_LD;
        end
      end
      ST_SETUP: begin
        if (w_last) begin
          w_st_nx  = ST_STROBE;
          w_cnt_nx = T_LD;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      ST_STROBE: begin
        if (w_last) begin
          w_st_nx  = ST_HOLD;
          w_cnt_nx = H_LD;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_last) begin
          w_st_nx = ST_DONE;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      ST_DONE: w_st_nx = ST_IDLE;
      default: w_st_nx = ST_IDLE;
    endcase
  end

  // Command capture on accept and read data capture at strobe end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_acc) begin
        r_write <= b.cmd_write;
        r_addr  <= b.cmd_addr;
        if (b.cmd_write) r_wdata <= b.cmd_wdata;
      end
      if (w_cap) r_rdata <= b.bus_data_i;
    end
  end

  assign b.cmd_ready   = (r_st == ST_IDLE);
  assign b.rsp_valid   = (r_st == ST_DONE);
  assign b.rsp_rdata   = r_rdata;
  assign b.bus_addr    = r_addr;
  assign b.bus_data_o  = r_wdata;
  assign b.bus_rd      = (r_st == ST_STROBE) & ~r_write;
  assign b.bus_wr      = (r_st == ST_STROBE) & r_write;
  assign b.bus_data_oe = w_act & r_write;

  ipm_sync2 #(.W(1)) u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (b.bus_int),
    .o_q   (w_int_s)
  );

`ifdef IPM_BM_IRQ_LATCH_EN
  logic r_int_d;
  logic r_irq;

  // Sticky flag set on a synced rising edge; a set beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_d <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_int_d <= w_int_s;
      if (w_int_s & ~r_int_d) r_irq <= 1'b1;
      else if (b.irq_clr)     r_irq <= 1'b0;
    end
  end

  assign b.irq_pending = r_irq;
`else
  logic w_unused;

  assign w_unused      = b.irq_clr;
  assign b.irq_pending = w_int_s;
`endif

endmodule

// File: tb/tb_ipm_bus_master.sv
// Directed bench for ipm_bus_master: write, read, back-to-back,
// mid-transaction reset and interrupt behaviour.
module tb_ipm_bus_master;

  logic       clk;
  logic       rst_n;
  logic [7:0] rd_val;
  int         n_chk;
  int         n_err;

  ipm_bus_master_if if0();
  ipm_bus_master_if if1();

  ipm_bus_master u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .b     (if0)
  );

  ipm_bus_master #(
    .SETUP_CYC  (2),
    .STROBE_CYC (3),
    .HOLD_CYC   (1)
  ) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .b     (if1)
  );

  assign if0.bus_data_i = if0.bus_rd ? rd_val : 8'h00;
  assign if1.bus_data_i = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "bench timeout");
  end

  initial begin
    int r1;
    int r2;
    int nrsp;
    int wr_n;
    int wr_1st;
    logic rdy7;
    logic rdy8;
    logic bad;
    n_chk = 0;
    n_err = 0;
    rd_val = 8'h00;
    rst_n = 1'b0;
    if0.cmd_valid = 1'b0;
    if0.cmd_write = 1'b0;
    if0.cmd_addr  = 4'h0;
    if0.cmd_wdata = 8'h00;
    if0.bus_int   = 1'b0;
    if0.irq_clr   = 1'b0;
    if1.cmd_valid = 1'b0;
    if1.cmd_write = 1'b0;
    if1.cmd_addr  = 4'h0;
    if1.cmd_wdata = 8'h00;
    if1.bus_int   = 1'b0;
    if1.irq_clr   = 1'b0;
    #3;
    chk("rst_rdy",   if0.cmd_ready,   1);
    chk("rst_rsp",   if0.rsp_valid,   0);
    chk("rst_rdata", if0.rsp_rdata,   0);
    chk("rst_addr",  if0.bus_addr,    0);
    chk("rst_dout",  if0.bus_data_o,  0);
    chk("rst_rd",    if0.bus_rd,      0);
    chk("rst_wr",    if0.bus_wr,      0);
    chk("rst_oe",    if0.bus_data_oe, 0);
    chk("rst_irq",   if0.irq_pending, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // write 0xA5 to addr 3, default timing
    if0.cmd_valid = 1'b1;
    if0.cmd_write = 1'b1;
    if0.cmd_addr  = 4'h3;
    if0.cmd_wdata = 8'hA5;
    chk("w_rdy0", if0.cmd_ready, 1);
    for (int c = 1; c <= 6; c++) begin
      cyc();
      if0.cmd_valid = 1'b0;
      chk("w_oe",  if0.bus_data_oe, 32'(c <= 4));
      chk("w_wr",  if0.bus_wr, 32'(c == 2 || c == 3));
      chk("w_rd",  if0.bus_rd, 0);
      chk("w_rsp", if0.rsp_valid, 32'(c == 5));
      chk("w_rdy", if0.cmd_ready, 32'(c == 6));
      if (c <= 4) begin
        chk("w_addr", if0.bus_addr, 3);
        chk("w_dout", if0.bus_data_o, 32'hA5);
      end
    end

    // read addr 0xF, responder drives 0x5C while RD is high
    rd_val = 8'h5C;
    if0.cmd_valid = 1'b1;
    if0.cmd_write = 1'b0;
    if0.cmd_addr  = 4'hF;
    if0.cmd_wdata = 8'hEE;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      if0.cmd_valid = 1'b0;
      chk("r_oe",  if0.bus_data_oe, 0);
      chk("r_rd",  if0.bus_rd, 32'(c == 2 || c == 3));
      chk("r_wr",  if0.bus_wr, 0);
      chk("r_rsp", if0.rsp_valid, 32'(c == 5));
      if (c <= 4) chk("r_addr", if0.bus_addr, 32'hF);
      if (c == 2) chk("r_rdata_pre", if0.rsp_rdata, 0);
      if (c == 5) chk("r_rdata", if0.rsp_rdata, 32'h5C);
    end
    chk("r_dout_keep", if0.bus_data_o, 32'hA5);

    // a following write must not disturb the read data
    if0.cmd_valid = 1'b1;
    if0.cmd_write = 1'b1;
    if0.cmd_addr  = 4'h1;
    if0.cmd_wdata = 8'h77;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      if0.cmd_valid = 1'b0;
      if (c == 5) begin
        chk("w2_rsp",   if0.rsp_valid, 1);
        chk("w2_rdata", if0.rsp_rdata, 32'h5C);
        chk("w2_dout",  if0.bus_data_o, 32'h77);
      end
    end
    chk("w2_addr_keep", if0.bus_addr, 1);

    // back-to-back on S=2 T=3 H=1 with valid held
    if1.cmd_valid = 1'b1;
    if1.cmd_write = 1'b1;
    if1.cmd_addr  = 4'h2;
    if1.cmd_wdata = 8'h3C;
    r1 = 0;
    r2 = 0;
    nrsp = 0;
    wr_n = 0;
    wr_1st = 0;
    rdy7 = 1'b1;
    rdy8 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (c == 9) if1.cmd_valid = 1'b0;
      if (if1.rsp_valid) begin
        nrsp++;
        if (nrsp == 1) r1 = c;
        if (nrsp == 2) r2 = c;
      end
      if (c <= 8 && if1.bus_wr) begin
        wr_n++;
        if (wr_1st == 0) wr_1st = c;
      end
      if (c == 7) rdy7 = if1.cmd_ready;
      if (c == 8) rdy8 = if1.cmd_ready;
    end
    chk("b2b_nrsp",   nrsp, 2);
    chk("b2b_rsp1",   r1, 7);
    chk("b2b_space",  r2 - r1, 8);
    chk("b2b_wr_w",   wr_n, 3);
    chk("b2b_wr_1st", wr_1st, 3);
    chk("b2b_rdy7",   rdy7, 0);
    chk("b2b_rdy8",   rdy8, 1);

    // reset during the second strobe cycle of a write
    if0.cmd_valid = 1'b1;
    if0.cmd_write = 1'b1;
    if0.cmd_addr  = 4'h9;
    if0.cmd_wdata = 8'h11;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      if0.cmd_valid = 1'b0;
    end
    chk("rs_wr_pre", if0.bus_wr, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_wr",   if0.bus_wr, 0);
    chk("rs_oe",   if0.bus_data_oe, 0);
    chk("rs_rdy",  if0.cmd_ready, 1);
    chk("rs_addr", if0.bus_addr, 0);
    #2;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      if (if0.rsp_valid || !if0.cmd_ready) bad = 1'b1;
    end
    chk("rs_after", bad, 0);

`ifdef IPM_BM_IRQ_LATCH_EN
    // one-cycle pulse sets the sticky flag 3 cycles later
    if0.bus_int = 1'b1;
    cyc();
    if0.bus_int = 1'b0;
    chk("irq_k1", if0.irq_pending, 0);
    cyc();
    chk("irq_k2", if0.irq_pending, 0);
    cyc();
    chk("irq_k3", if0.irq_pending, 1);
    cyc();
    cyc();
    cyc();
    chk("irq_stick", if0.irq_pending, 1);
    // clear coinciding with a new edge: set wins
    if0.bus_int = 1'b1;
    cyc();
    if0.bus_int = 1'b0;
    cyc();
    if0.irq_clr = 1'b1;
    cyc();
    if0.irq_clr = 1'b0;
    chk("irq_setwin", if0.irq_pending, 1);
    // clear alone
    cyc();
    if0.irq_clr = 1'b1;
    cyc();
    if0.irq_clr = 1'b0;
    chk("irq_clr", if0.irq_pending, 0);
    cyc();
    cyc();
    chk("irq_clr_keep", if0.irq_pending, 0);
`else
    // level follows int with 2-cycle delay, clear ignored
    if0.irq_clr = 1'b1;
    if0.bus_int = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      cyc();
      if (j == 4) if0.bus_int = 1'b0;
      chk("irq_lvl", if0.irq_pending, 32'(j >= 2 && j <= 5));
    end
    if0.irq_clr = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
